saw_sin_noise_gen: RTL and testbench
====================================

SAW_SIN_NOISE_GEN -- requirements
Module: saw_sin_noise_gen

Interface
REQ-001 The block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-002 Parameter: LFSR_SEED, default 16'hACE1, non-zero LFSR load value.
REQ-003 Port: clk, input, 1, rising-edge clock for all state.
REQ-004 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port: en, input, 1, run enable.
REQ-006 Port: sel, input, 2, waveform select: 00 saw, 01 sine, 10 noise, 11 midscale.
REQ-007 Port: freq, input, 12, unsigned phase increment per clock.
REQ-008 Port: amp, input, 3, attenuation exponent; gain is 2^-amp.
REQ-009 Port: phase, input, 8, phase offset; 256 counts equal 360 degrees.
REQ-010 Port: dac_data, output, 14, offset-binary sample; midscale is 14'h2000.

Function
REQ-011 The block SHALL hold a 24-bit phase accumulator acc; while en=1, acc <= acc + freq mod 2^24 each clock; while en=0, acc holds.
REQ-012 The phase word SHALL be P = acc[23:10] + {phase, 6'b0}, taken mod 2^14.
REQ-013 Saw raw sample SHALL equal P, ramping from 0 to 16383 and wrapping to 0.
REQ-014 Sine SHALL use a 256-entry quarter-wave table: mag[i] = round(8191*sin(pi/2*(2i+1)/512)), with i = P[11:4].
REQ-015 Sine quadrant SHALL be q = P[13:12]: q0 gives +mag[i], q1 gives +mag[255-i], q2 gives -mag[i], q3 gives -mag[255-i]; raw = 8192 + signed value.
REQ-016 Noise SHALL come from a 16-bit Galois LFSR, right-shifting; when the shifted-out bit is 1, the new state is XORed with 16'hB400.
REQ-017 The LFSR SHALL advance only while en=1, and its period SHALL be 65535.
REQ-018 Noise raw sample SHALL be lfsr[13:0] of the current LFSR state.
REQ-019 If the LFSR state is ever all-zero, it SHALL reload LFSR_SEED on the next clock.
REQ-020 sel=11 SHALL give raw 14'h2000; en=0 SHALL also force raw 14'h2000.
REQ-021 Pipeline stage 1 SHALL register the raw sample selected from the current acc and LFSR state.
REQ-022 Pipeline stage 2 SHALL register dac_data = 8192 + ((raw - 8192) >>> amp), using signed 15-bit arithmetic.
REQ-023 Latency: dac_data SHALL reflect the acc/LFSR/sel/amp/phase/en values present 2 rising edges earlier; the block SHALL never overflow or saturate.
REQ-024 Changes to freq, phase, amp or sel SHALL take effect without glitches or resetting acc.

Reset
REQ-025 On rst_n low, the block SHALL immediately set acc=0, LFSR=LFSR_SEED, the stage-1 register to 14'h2000, and dac_data to 14'h2000.
REQ-026 Reset asserted mid-operation SHALL abandon the pipeline contents; the first valid sample SHALL appear 2 clocks after release with en=1.

Configuration
REQ-027 Macro WAVE_NOISE_EN defined: the LFSR and the noise path SHALL be included.
REQ-028 Macro WAVE_NOISE_EN undefined: no LFSR logic SHALL exist, and sel=10 SHALL behave as sel=11 (midscale).

Verification
REQ-029 Reset check: hold rst_n low, then release with en=0 -> dac_data stays 14'h2000 for 10 clocks.
REQ-030 Saw check: sel=00, amp=0, phase=0, freq=12'h400, en=1 after reset -> dac_data reads 0,1,2,... from the 3rd edge and wraps 16383 to 0.
REQ-031 Sine peak check: sel=01, freq=0, amp=0 -> phase=00 gives 8217, phase=40 gives 16383, phase=C0 gives 1, phase=80 gives 8167.
REQ-032 Amplitude check: sine with phase=40 -> amp=1 gives 12287, amp=7 gives 8255; phase=C0 with amp=1 gives 4096.
REQ-033 Noise check (WAVE_NOISE_EN defined): en=1 after reset, sel=10, amp=0 -> dac_data gives 14'h2CE1 then 14'h2270; the LFSR returns to 16'hACE1 after 65535 steps.
REQ-034 Freeze check: drop en to 0 mid-run -> dac_data is 14'h2000 2 clocks later; on re-enable, the saw resumes from the held acc value.

Source files
------------

// File: rtl/saw_sin_noise_gen.sv
// rtl/saw_sin_noise_gen.sv - DDS waveform source (saw, quarter-wave sine, LFSR noise, midscale) with 2-stage attenuating output pipe.
// Define WAVE_NOISE_EN to build the LFSR noise source; without it sel=10 yields midscale.
module saw_sin_noise_gen #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  sel,
  input  logic [11:0] freq,
  input  logic [2:0]  amp,
  input  logic [7:0]  phase,
  output logic [13:0] dac_data
);
  localparam logic [13:0]  MIDSCALE = 14'h2000;
  localparam logic [127:0] PI_Q60   = 128'h3243F6A8885A308D;

  // Elaboration-time Taylor series in Q60; only the rounded 13-bit results reach hardware.
  function automatic logic [12:0] sin_mag(input int idx);
    logic [127:0] x, x2, term, sum;
    x    = (PI_Q60 * 128'(2 * idx + 1)) >> 10;
    x2   = (x * x) >> 60;
    term = x;
    sum  = x;
    for (int k = 1; k <= 12; k++) begin
      term = (term * x2) >> 60;
      term = term / 128'((2 * k) * (2 * k + 1));
      if (k % 2 == 1) sum = sum - term;
      else            sum = sum + term;
    end
    return 13'(((sum * 128'd8191) + (128'd1 << 59)) >> 60);
  endfunction

  logic [12:0] sin_tab [256];
  for (genvar g = 0; g < 256; g++) begin : g_sin
    localparam logic [12:0] MAG = sin_mag(g);
    assign sin_tab[g] = MAG;
  end

  logic [23:0] acc;
  logic [13:0] p_word;
  logic [1:0]  quad;
  logic [7:0]  idx;
  logic [7:0]  tab_idx;
  logic [12:0] mag;
  logic [13:0] sine_raw;
  logic [13:0] noise_raw;
  logic [13:0] raw_next;
  logic [13:0] raw_q;
  logic [2:0]  amp_q;
  logic signed [14:0] centered;
  logic signed [14:0] scaled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  acc <= '0;
    else if (en) acc <= acc + {12'h000, freq};
  end

  assign p_word  = acc[23:10] + {phase, 6'b0};
  assign quad    = p_word[13:12];
  assign idx     = p_word[11:4];
  // Odd quadrants read the table backwards: ~idx == 255 - idx.
  assign tab_idx = quad[0] ? ~idx : idx;
  assign mag     = sin_tab[tab_idx];
  assign sine_raw = quad[1] ? (MIDSCALE - {1'b0, mag}) : (MIDSCALE + {1'b0, mag});

`ifdef WAVE_NOISE_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            lfsr <= LFSR_SEED;
    else if (lfsr == '0)   lfsr <= LFSR_SEED;
    else if (en)           lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign noise_raw = lfsr[13:0];
`else
  assign noise_raw = MIDSCALE;
`endif

  always_comb begin
    raw_next = MIDSCALE;
    if (en) begin
      unique case (sel)
        2'b00:   raw_next = p_word;
        2'b01:   raw_next = sine_raw;
        2'b10:   raw_next = noise_raw;
        default: raw_next = MIDSCALE;
      endcase
    end
  end

  // amp travels with its sample so a gain change lines up with the waveform it was applied to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= MIDSCALE;
      amp_q <= '0;
    end else begin
      raw_q <= raw_next;
      amp_q <= amp;
    end
  end

  assign centered = $signed({1'b0, raw_q}) - 15'sd8192;
  assign scaled   = centered >>> amp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dac_data <= MIDSCALE;
    else        dac_data <= 14'(scaled + 15'sd8192);
  end
endmodule

// File: tb/tb_saw_sin_noise_gen.sv
// tb/tb_saw_sin_noise_gen.sv - scoreboard bench for saw_sin_noise_gen; expectations are queued by the driver and popped by a negedge monitor.
module tb_saw_sin_noise_gen;
  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  sel;
  logic [11:0] freq;
  logic [2:0]  amp;
  logic [7:0]  phase;
  logic [13:0] dac_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic [13:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [7:0]  ph;
    logic [2:0]  am;
    logic [13:0] val;
  } sine_vec_t;

  saw_sin_noise_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sel      (sel),
    .freq     (freq),
    .amp      (amp),
    .phase    (phase),
    .dac_data (dac_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: dac_data=%h (%0d) expected %h (%0d) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, dac_data, e.val);
    end
  end

  // Inputs are set at a negedge before calling; the sample they produce is visible two edges later.
  task automatic tick(input bit chk, input logic [13:0] val, input string name);
    if (chk) exp_q.push_back('{due: cyc + 2, val: val, name: name});
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 check("reset_async", dac_data, 14'h2000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [13:0] kk;
    logic [13:0] pv;
    int          c;
    sine_vec_t   sv [10];

    sv[0] = '{8'h00, 3'd0, 14'd8217};
    sv[1] = '{8'h40, 3'd0, 14'd16383};
    sv[2] = '{8'hC0, 3'd0, 14'd1};
    sv[3] = '{8'h80, 3'd0, 14'd8167};
    sv[4] = '{8'h20, 3'd0, 14'd14002};
    sv[5] = '{8'h60, 3'd0, 14'd13966};
    sv[6] = '{8'hA0, 3'd0, 14'd2382};
    sv[7] = '{8'h40, 3'd1, 14'd12287};
    sv[8] = '{8'h40, 3'd7, 14'd8255};
    sv[9] = '{8'hC0, 3'd1, 14'd4096};

    rst_n = 1'b0;
    en    = 1'b0;
    sel   = 2'b00;
    freq  = 12'h400;
    amp   = 3'd0;
    phase = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_hold", dac_data, 14'h2000);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) tick(1, 14'h2000, "reset_idle");

    en = 1'b1;
    kk = '0;
    for (int i = 0; i < 40; i++) begin
      tick(1, kk, "saw");
      kk++;
    end

    en = 1'b0;
    for (int i = 0; i < 4; i++) tick(1, 14'h2000, "freeze");

    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1, kk, "saw_resume");
      kk++;
    end

    phase = 8'h10;
    for (int i = 0; i < 8; i++) begin
      pv = kk + {phase, 6'b0};
      tick(1, pv, "saw_phase");
      kk++;
    end

    amp = 3'd2;
    for (int i = 0; i < 4; i++) begin
      pv = kk + {phase, 6'b0};
      c  = int'(pv) - 8192;
      tick(1, 14'(8192 + (c >>> 2)), "saw_amp2");
      kk++;
    end
    amp = 3'd0;

    phase = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      pv = kk + {phase, 6'b0};
      tick(1, pv, "saw_wrap");
      kk++;
    end

    repeat (2) tick(0, '0, "");
    phase = 8'h00;
    async_reset();
    kk = '0;
    for (int i = 0; i < 5; i++) begin
      tick(1, kk, "saw_after_reset");
      kk++;
    end

    sel  = 2'b01;
    freq = 12'h000;
    for (int v = 0; v < 10; v++) begin
      phase = sv[v].ph;
      amp   = sv[v].am;
      for (int i = 0; i < 3; i++) tick(1, sv[v].val, "sine");
    end
    amp = 3'd0;

    sel = 2'b11;
    for (int i = 0; i < 3; i++) tick(1, 14'h2000, "midscale");

`ifdef WAVE_NOISE_EN
    repeat (2) tick(0, '0, "");
    sel = 2'b10;
    async_reset();
    tick(1, 14'h2CE1, "noise");
    tick(1, 14'h2270, "noise");
    tick(1, 14'h3138, "noise");
    tick(1, 14'h389C, "noise");
    tick(1, 14'h1C4E, "noise");
    tick(1, 14'h0E27, "noise");
    tick(1, 14'h3313, "noise");
    for (int i = 0; i < 65528; i++) tick(0, '0, "");
    tick(1, 14'h2CE1, "noise_period");
    tick(1, 14'h2270, "noise_period");
`else
    sel = 2'b10;
    for (int i = 0; i < 4; i++) tick(1, 14'h2000, "noise_disabled");
`endif

    repeat (3) tick(0, '0, "");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: cycle=%0d expected finish before time limit", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule
